lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Sequences every core load/store onto the shared single-port data memory. It accepts one access per start pulse and issues a request/grant transaction to memory. It waits a variable latency for the response, then returns sign- or zero-extended load data, or completes a byte-lane-masked store. The core stalls on busy; rd writeback uses done/rdata.

Parameters:
TIMEOUT_CYC, 64, max cycles waiting for mem_gnt or mem_rvalid before fault (>=2)
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
start  in  1  one-cycle request from core; sampled only in IDLE
is_store  in  1  1 = store, 0 = load
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 stores
addr  in  ADDR_W  effective byte address (rs1 + sext imm, computed upstream)
wdata  in  32  rs2 data for stores
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result; valid when done && !is_store of captured op
fault  out  1  with done: misaligned, illegal funct3, or timeout
mem_req  out  1  request valid, held until mem_gnt
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  store data replicated into lanes
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  response valid (load data or store ack)
mem_rdata  in  32  word read data

Behaviour:
- Reset (rst_n low at posedge): state IDLE; busy, done, fault, mem_req, mem_we = 0; rdata, mem_addr, mem_be, mem_wdata, timeout counter = 0. Reset mid-transaction abandons it; late mem_rvalid after reset in IDLE is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on start, capture is_store, funct3, addr[1:0], wdata; busy=1. Check legality: load funct3 in {000,001,010,100,101}, store funct3 in {000,001,010}; H requires addr[0]=0; W requires addr[1:0]=0. Illegal -> RESP with fault=1, no memory request. Legal -> REQ, mem_req=1 next cycle.
- mem_be: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111. Loads drive the same mask.
- mem_wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
- REQ: mem_req, mem_we, mem_addr, mem_be, mem_wdata held stable until mem_gnt. On gnt, mem_req=0 next cycle -> WAIT. If mem_rvalid arrives the same cycle as mem_gnt, go directly to RESP.
- WAIT: on mem_rvalid -> RESP. For loads, select lane by addr[1:0]: byte = mem_rdata[8*a+7:8*a]; half = mem_rdata[16*a1+15:16*a1]. Extend per funct3 (000/001 sign, 100/101 zero, 010 pass) into rdata.
- RESP: done=1 for exactly one cycle, busy=1 this cycle, fault per result; then IDLE with busy=0. start is ignored while busy, including the RESP cycle.
- Timeout: counter clears on entering REQ and again on entering WAIT, and increments each cycle in REQ/WAIT. Reaching TIMEOUT_CYC -> mem_req=0, RESP with fault=1, rdata=0.
- Faulting or store completions drive rdata=0.
- Minimum latency for a legal op: start at cycle 0; mem_req at 1; gnt+rvalid at 1; done at 2.

Test Plan:
- LB addr=0x1003, mem_rdata=0x80FF_1234, gnt cycle 1, rvalid cycle 3 -> mem_addr=0x1000, mem_be=1000, done cycle 4, rdata=0xFFFF_FF80, fault=0.
- LHU addr=0x2002, mem_rdata=0xBEEF_0000 with gnt+rvalid in the same cycle -> mem_be=1100, rdata=0x0000_BEEF, done 2 cycles after start.
- SB addr=0x0001, wdata=0x1234_56AB -> mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB; rvalid ack -> done, fault=0, rdata=0.
- LW addr=0x0006 -> no mem_req ever asserted, done+fault next cycle; store funct3=100 -> same result.
- LW with mem_gnt held low, TIMEOUT_CYC=4 -> mem_req drops after 4 REQ cycles, done+fault, rdata=0. Then a start pulsed during RESP is ignored.
- rst_n low while in WAIT -> next cycle all outputs 0, state IDLE; a subsequent mem_rvalid produces no done; a new LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences core loads/stores onto a single-port req/gnt data memory
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              fault_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t            state_q;
  logic              st_q, busy_q, done_q, fault_q, req_q, we_q;
  logic [2:0]        f3_q;
  logic [1:0]        a_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       rdata_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic              legal_d, to_d;
  logic [3:0]        be_d;
  logic [31:0]       wd_d, ld_d;
  logic [7:0]        byte_d;
  logic [15:0]       half_d;
  always_comb begin
    legal_d = (is_store_i ? !funct3_i[2] : funct3_i[2:1] != 2'b11) && funct3_i[1:0] != 2'b11 &&
              !(funct3_i[0] && addr_i[0]) && !(funct3_i[1] && addr_i[1:0] != 2'b00);
    be_d    = funct3_i[1] ? 4'hF : (funct3_i[0] ? 4'b0011 : 4'b0001) << addr_i[1:0];
    wd_d    = funct3_i[1] ? wdata_i : funct3_i[0] ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
    byte_d  = 8'(mem_rdata_i >> {a_q, 3'b000});
    half_d  = 16'(mem_rdata_i >> {a_q[1], 4'b0000});
    // f3[2] selects zero extension, f3[1] a full word
    ld_d    = st_q ? 32'd0 : f3_q[1] ? mem_rdata_i :
              f3_q[0] ? {{16{half_d[15] & !f3_q[2]}}, half_d} : {{24{byte_d[7] & !f3_q[2]}}, byte_d};
    to_d    = cnt_q == CW'(TIMEOUT_CYC - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      st_q    <= 1'b0;
      f3_q    <= 3'd0;
      a_q     <= 2'd0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      wdata_q <= 32'd0;
      addr_q  <= '0;
      be_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          busy_q  <= 1'b1;
          st_q    <= is_store_i;
          f3_q    <= funct3_i;
          a_q     <= addr_i[1:0];
          addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
          be_q    <= be_d;
          wdata_q <= wd_d;
          cnt_q   <= '0;
          rdata_q <= 32'd0;
          state_q <= legal_d ? REQ : RESP;
          req_q   <= legal_d;
          we_q    <= legal_d & is_store_i;
          done_q  <= !legal_d;
          fault_q <= !legal_d;
        end
        REQ: begin
          if (mem_gnt_i || to_d) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
          // a same-cycle response skips WAIT entirely
          if (mem_gnt_i && mem_rvalid_i) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            rdata_q <= ld_d;
          end else if (mem_gnt_i) begin
            state_q <= WAIT;
          end else if (to_d) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            rdata_q <= ld_d;
          end else if (to_d) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vectors, corner sequences and random ops against a reference model
module tb_lsu_ctrl;
  localparam int T = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_store = 1'b0;
  logic [2:0] funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, mem_rdata = 32'd0;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic busy, done, fault, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  lsu_ctrl #(.TIMEOUT_CYC(T), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .is_store_i(is_store), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done), .rdata_o(rdata),
    .fault_o(fault), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata));
  typedef struct {
    bit st; bit [2:0] f3; bit [31:0] addr, wdata, mrd; int gd, rd; bit poke;
    bit fault; bit [31:0] rdata; bit [3:0] be; bit [31:0] mwd; int lat;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_be"}, mem_be, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask
  function automatic vec_t model(input bit st, input bit [2:0] f3, input bit [31:0] ad,
                                 input bit [31:0] wd, input bit [31:0] mrd, input int gd, input int rd);
    vec_t v;
    int n, a, sv;
    bit ok;
    bit [31:0] lane;
    a = int'(ad % 4);
    n = 1 << f3[1:0];
    ok = (st ? f3 <= 3'd2 : f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (a % n == 0);
    v = '{st, f3, ad, wd, mrd, gd, rd, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 0};
    v.be = n >= 4 ? 4'hF : 4'(((1 << n) - 1) << a);
    v.mwd = n == 1 ? {24'd0, wd[7:0]} * 32'h0101_0101 : n == 2 ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
    lane = mrd >> (8 * a);
    if (!ok) begin
      v.lat = 1; v.fault = 1;
    end else if (gd >= T) begin
      v.lat = 1 + T; v.fault = 1;
    end else if (rd > T) begin
      v.lat = 2 + gd + T; v.fault = 1;
    end else begin
      v.lat = 2 + gd + rd;
      if (!st) begin
        if (n == 4) sv = int'(mrd);
        else if (n == 2) begin
          sv = int'(lane % 65536);
          if (!f3[2] && sv >= 32768) sv = sv - 65536;
        end else begin
          sv = int'(lane % 256);
          if (!f3[2] && sv >= 128) sv = sv - 256;
        end
        v.rdata = 32'(sv);
      end
    end
    return v;
  endfunction
  task automatic do_op(input vec_t v);
    bit seen, granted, got;
    int rq, gc;
    seen = 0; granted = 0; got = 0; rq = 0; gc = 0;
    start = 1; is_store = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      start = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      chk("busy_during_op", busy, 1);
      if (done) begin
        got = 1;
        chk("done_latency", c, v.lat);
        chk("fault", fault, v.fault);
        chk("rdata", rdata, v.rdata);
        chk("req_low_at_done", mem_req, 0);
        chk("req_issued", seen, v.lat > 1);
        if (v.poke) begin
          start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h40;
        end
      end else if (mem_req) begin
        seen = 1;
        chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        chk("mem_be", mem_be, v.be);
        chk("mem_we", mem_we, v.st);
        if (v.st) chk("mem_wdata", mem_wdata, v.mwd);
        if (rq == v.gd) begin
          mem_gnt = 1; granted = 1; gc = c;
          if (v.rd == 0) begin
            mem_rvalid = 1; mem_rdata = v.mrd;
          end
        end
        rq++;
      end else if (granted && c - gc == v.rd) begin
        mem_rvalid = 1; mem_rdata = v.mrd;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL done_wait: no done within 40 cycles, required at cycle %0d", v.lat);
    end
    @(negedge clk);
    start = 0; mem_gnt = 0; mem_rvalid = 0;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("req_after_done", mem_req, 0);
    if (v.poke) begin
      @(negedge clk);
      chk("poke_busy", busy, 0);
      chk("poke_req", mem_req, 0);
      chk("poke_done", done, 0);
    end
  endtask
  initial begin
    tbl[0]  = '{0, 3'b000, 32'h1003, 32'h0,         32'h80FF_1234, 0, 2, 0, 0, 32'hFFFF_FF80, 4'b1000, 32'h0,         4};
    tbl[1]  = '{0, 3'b101, 32'h2002, 32'h0,         32'hBEEF_0000, 0, 0, 0, 0, 32'h0000_BEEF, 4'b1100, 32'h0,         2};
    tbl[2]  = '{1, 3'b000, 32'h0001, 32'h1234_56AB, 32'h0,         0, 1, 0, 0, 32'h0,         4'b0010, 32'hABAB_ABAB, 3};
    tbl[3]  = '{0, 3'b010, 32'h0006, 32'h0,         32'h0,         0, 0, 0, 1, 32'h0,         4'b1111, 32'h0,         1};
    tbl[4]  = '{1, 3'b100, 32'h0100, 32'h5555_5555, 32'h0,         0, 0, 0, 1, 32'h0,         4'b0001, 32'h0,         1};
    tbl[5]  = '{0, 3'b010, 32'h0020, 32'h0,         32'h1111_1111, 9, 0, 1, 1, 32'h0,         4'b1111, 32'h0,         5};
    tbl[6]  = '{1, 3'b010, 32'h0010, 32'hDEAD_BEEF, 32'h0,         2, 3, 0, 0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 7};
    tbl[7]  = '{0, 3'b001, 32'h0006, 32'h0,         32'h8001_7FFF, 1, 1, 0, 0, 32'hFFFF_8001, 4'b1100, 32'h0,         4};
    tbl[8]  = '{0, 3'b000, 32'h0001, 32'h0,         32'h0000_7F00, 0, 4, 0, 0, 32'h0000_007F, 4'b0010, 32'h0,         6};
    tbl[9]  = '{0, 3'b010, 32'h0008, 32'h0,         32'h2222_2222, 0, 5, 0, 1, 32'h0,         4'b1111, 32'h0,         6};
    tbl[10] = '{0, 3'b001, 32'h0003, 32'h0,         32'h0,         0, 0, 0, 1, 32'h0,         4'b1000, 32'h0,         1};
    tbl[11] = '{1, 3'b001, 32'h0002, 32'h0000_C0DE, 32'h0,         0, 0, 0, 0, 32'h0,         4'b1100, 32'hC0DE_C0DE, 2};
    @(negedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) do_op(tbl[i]);
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h50;
    @(negedge clk);
    start = 0;
    chk("rst_seq_req", mem_req, 1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("rst_seq_wait", mem_req, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk_idle_outputs("mid_reset");
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 0;
    chk("late_rvalid_done", done, 0);
    chk("late_rvalid_busy", busy, 0);
    @(negedge clk);
    chk("late_rvalid_done2", done, 0);
    do_op(model(0, 3'b010, 32'h0000_0060, 32'h0, 32'h1357_9BDF, 1, 1));
    for (int i = 0; i < 200; i++)
      do_op(model(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 5))));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
